// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the pipeline's shared ALU through a req/gnt handshake.
// Produces the low WIDTH bits of op_a*op_b without a dedicated multiplier array.
module alu_mul_seq #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'b1110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_NOP = 4'b1111;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        TEST,
        ADD,
        SHL,
        SHR,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] mp;
    logic [CNT_W-1:0] cnt;
    logic             exit_now;

    // Early exit stops once no multiplier bits remain; otherwise latency is fixed at WIDTH iterations.
    always_comb begin
        if (EARLY_EXIT) begin
            exit_now = (mp == '0);
        end else begin
            exit_now = (cnt == CNT_W'(WIDTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            mc      <= '0;
            mp      <= '0;
            cnt     <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_req <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        acc   <= '0;
                        mc    <= op_a;
                        mp    <= op_b;
                        cnt   <= '0;
                        state <= TEST;
                        busy  <= 1'b1;
                    end
                end
                TEST: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (exit_now) begin
                        state  <= DONE;
                        result <= acc;
                        done   <= 1'b1;
                    end else begin
                        state   <= mp[0] ? ADD : SHL;
                        alu_req <= 1'b1;
                    end
                end
                ADD: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        alu_req <= 1'b0;
                    end else if (alu_gnt) begin
                        acc   <= alu_out;
                        state <= SHL;
                    end
                end
                SHL: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        alu_req <= 1'b0;
                    end else if (alu_gnt) begin
                        mc    <= alu_out;
                        state <= SHR;
                    end
                end
                SHR: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        alu_req <= 1'b0;
                    end else if (alu_gnt) begin
                        mp      <= alu_out;
                        cnt     <= cnt + CNT_W'(1);
                        state   <= TEST;
                        alu_req <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    alu_req <= 1'b0;
                end
            endcase
        end
    end

    // Operands are held steady from the registers for as long as the grant is withheld.
    always_comb begin
        alu_ctrl = OP_NOP;
        alu_a    = '0;
        alu_b    = '0;
        case (state)
            ADD: begin
                alu_ctrl = OP_ADD;
                alu_a    = mc;
                alu_b    = acc;
            end
            SHL: begin
                alu_ctrl = OP_SHL;
                alu_a    = ONE;
                alu_b    = mc;
            end
            SHR: begin
                alu_ctrl = OP_SHR;
                alu_a    = ONE;
                alu_b    = mp;
            end
            default: begin
            end
        endcase
    end

endmodule
